// File: rtl/execute_cycle_if.sv
// execute_cycle_if: E-stage bundle from decode, branch resolution back to fetch,
// and the EX/MEM bundle toward the memory stage.
// The slave side is the execute stage; the master side is its environment.
interface execute_cycle_if #(
    parameter int unsigned WIDTH = 32
);
    // decode -> execute
    logic             RegWriteE;
    logic             ALU_SrcE;
    logic             MemWriteE;
    logic             ResultSrcE;
    logic             BranchE;
    logic [2:0]       ALUControlE;
    logic [WIDTH-1:0] RD1_E;
    logic [WIDTH-1:0] RD2_E;
    logic [WIDTH-1:0] Imm_Ext_E;
    logic [4:0]       RD_E;
    logic [WIDTH-1:0] PCE;
    logic [WIDTH-1:0] PCPlus4E;
    // writeback result and hazard-unit selects
    logic [WIDTH-1:0] ResultW;
    logic [1:0]       ForwardA_E;
    logic [1:0]       ForwardB_E;
    // branch resolution (combinational)
    logic             PCSrcE;
    logic [WIDTH-1:0] PCTargetE;
    // EX/MEM register outputs
    logic             RegWriteM;
    logic             MemWriteM;
    logic             ResultSrcM;
    logic [4:0]       RD_M;
    logic [WIDTH-1:0] ALU_ResultM;
    logic [WIDTH-1:0] WriteDataM;
    logic [WIDTH-1:0] PCPlus4M;

    modport master (
        output RegWriteE, ALU_SrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ResultW, ForwardA_E, ForwardB_E,
        input  PCSrcE, PCTargetE,
               RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALU_ResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, ALU_SrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ResultW, ForwardA_E, ForwardB_E,
        output PCSrcE, PCTargetE,
               RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALU_ResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/execute_cycle.sv
// execute_cycle: RV32I execute stage -- operand forwarding, ALU, BEQ resolution,
// branch target, and the EX/MEM pipeline register (1-cycle latency, no stall).
// Optional: define EXECUTE_BRANCH_COUNT_EN to add the BranchTakenCnt output.
module execute_cycle #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    execute_cycle_if.slave   bus
`ifdef EXECUTE_BRANCH_COUNT_EN
    ,
    output logic [WIDTH-1:0] BranchTakenCnt
`endif
);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_RSV4 = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_RSV6 = 3'b110,
        ALU_RSV7 = 3'b111
    } alu_op_e;

    alu_op_e          alu_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_result;
    logic             slt;
    logic             zero;
    logic             pc_src;

    logic             reg_write_q;
    logic             mem_write_q;
    logic             result_src_q;
    logic [4:0]       rd_q;
    logic [WIDTH-1:0] alu_result_q;
    logic [WIDTH-1:0] write_data_q;
    logic [WIDTH-1:0] pc_plus4_q;

    assign alu_op = alu_op_e'(bus.ALUControlE);

    // Forward mux A: register file, writeback result, or previous ALU result
    always_comb begin
        src_a = bus.RD1_E;
        case (bus.ForwardA_E)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = bus.RD1_E;
        endcase
    end

    // Forward mux B: same encoding; its output is also the store data
    always_comb begin
        write_data = bus.RD2_E;
        case (bus.ForwardB_E)
            2'b01:   write_data = bus.ResultW;
            2'b10:   write_data = alu_result_q;
            default: write_data = bus.RD2_E;
        endcase
    end

    assign src_b = bus.ALU_SrcE ? bus.Imm_Ext_E : write_data;
    assign slt   = $signed(src_a) < $signed(src_b);

    // ALU: arithmetic wraps, reserved encodings produce zero
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt};
            default: alu_result = '0;
        endcase
    end

    assign zero          = (alu_result == '0);
    assign pc_src        = zero & bus.BranchE;
    assign bus.PCSrcE    = pc_src;
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

    // EX/MEM register: captures every cycle, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= bus.RegWriteE;
            mem_write_q  <= bus.MemWriteE;
            result_src_q <= bus.ResultSrcE;
            rd_q         <= bus.RD_E;
            alu_result_q <= alu_result;
            write_data_q <= write_data;
            pc_plus4_q   <= bus.PCPlus4E;
        end
    end

    assign bus.RegWriteM   = reg_write_q;
    assign bus.MemWriteM   = mem_write_q;
    assign bus.ResultSrcM  = result_src_q;
    assign bus.RD_M        = rd_q;
    assign bus.ALU_ResultM = alu_result_q;
    assign bus.WriteDataM  = write_data_q;
    assign bus.PCPlus4M    = pc_plus4_q;

`ifdef EXECUTE_BRANCH_COUNT_EN
    logic [WIDTH-1:0] taken_cnt_q;

    // Taken-branch counter, wraps naturally at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_cnt_q <= '0;
        end else if (pc_src) begin
            taken_cnt_q <= taken_cnt_q + 1'b1;
        end
    end

    assign BranchTakenCnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: scoreboard bench for execute_cycle. Stimulus pushes the
// hand-computed EX/MEM bundle into a queue; a monitor pops one entry after
// each clock edge and compares it with the registered outputs.
module tb_execute_cycle;

    logic clk;
    logic rst;

    execute_cycle_if #(.WIDTH(32)) bus ();

`ifdef EXECUTE_BRANCH_COUNT_EN
    logic [31:0] taken_cnt;
`endif

    execute_cycle #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef EXECUTE_BRANCH_COUNT_EN
        ,
        .BranchTakenCnt (taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mw;
        logic        rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // stimulus-side context shared with issue()
    logic        rw_e  = 1'b1;
    logic        mw_e  = 1'b0;
    logic        rs_e  = 1'b0;
    logic        br_e  = 1'b0;
    logic [31:0] resw  = '0;
    logic [31:0] pc_e  = 32'h0000_0000;
    logic [4:0]  rd_e  = 5'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".RegWriteM"},   32'(bus.RegWriteM),  '0);
        chk({tag, ".MemWriteM"},   32'(bus.MemWriteM),  '0);
        chk({tag, ".ResultSrcM"},  32'(bus.ResultSrcM), '0);
        chk({tag, ".RD_M"},        32'(bus.RD_M),       '0);
        chk({tag, ".ALU_ResultM"}, bus.ALU_ResultM,     '0);
        chk({tag, ".WriteDataM"},  bus.WriteDataM,      '0);
        chk({tag, ".PCPlus4M"},    bus.PCPlus4M,        '0);
    endtask

    // Drive one E-stage bundle at the falling edge and queue its expected M bundle
    task automatic issue(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic alusrc, input logic [31:0] imm,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] exp_alu, input logic [31:0] exp_wd);
        exp_t e;
        @(negedge clk);
        bus.RegWriteE   = rw_e;
        bus.MemWriteE   = mw_e;
        bus.ResultSrcE  = rs_e;
        bus.BranchE     = br_e;
        bus.ALUControlE = ctl;
        bus.ALU_SrcE    = alusrc;
        bus.RD1_E       = a;
        bus.RD2_E       = b;
        bus.Imm_Ext_E   = imm;
        bus.ForwardA_E  = fa;
        bus.ForwardB_E  = fb;
        bus.ResultW     = resw;
        bus.RD_E        = rd_e;
        bus.PCE         = pc_e;
        bus.PCPlus4E    = pc_e + 32'd4;
        e.rw  = rw_e;
        e.mw  = mw_e;
        e.rs  = rs_e;
        e.rd  = rd_e;
        e.alu = exp_alu;
        e.wd  = exp_wd;
        e.pc4 = pc_e + 32'd4;
        exp_q.push_back(e);
        pc_e = pc_e + 32'd4;
        rd_e = rd_e + 5'd1;
    endtask

    // Monitor: one expected bundle per clock edge while the queue holds entries
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("RegWriteM",   32'(bus.RegWriteM),  32'(e.rw));
                chk("MemWriteM",   32'(bus.MemWriteM),  32'(e.mw));
                chk("ResultSrcM",  32'(bus.ResultSrcM), 32'(e.rs));
                chk("RD_M",        32'(bus.RD_M),       32'(e.rd));
                chk("ALU_ResultM", bus.ALU_ResultM,     e.alu);
                chk("WriteDataM",  bus.WriteDataM,      e.wd);
                chk("PCPlus4M",    bus.PCPlus4M,        e.pc4);
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b0;

        // Reset held: random inputs must not disturb the cleared register
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.RegWriteE   = 1'b1;
            bus.MemWriteE   = 1'b1;
            bus.ResultSrcE  = 1'b1;
            bus.BranchE     = 1'($urandom);
            bus.ALUControlE = 3'($urandom);
            bus.ALU_SrcE    = 1'($urandom);
            bus.RD1_E       = $urandom;
            bus.RD2_E       = $urandom;
            bus.Imm_Ext_E   = $urandom;
            bus.ForwardA_E  = 2'($urandom);
            bus.ForwardB_E  = 2'($urandom);
            bus.ResultW     = $urandom;
            bus.RD_E        = 5'd31;
            bus.PCE         = $urandom;
            bus.PCPlus4E    = $urandom;
            @(posedge clk);
            #1;
            chk_zero("reset_hold");
        end
        // release between edges so no random bundle gets captured
        #1 rst = 1'b1;

        // first cycle after reset: forwarding from the EX/MEM register gives 0
        issue(3'b000, 32'hDEAD, 32'd5, 1'b0, 32'd0, 2'b10, 2'b00, 32'd5, 32'd5);
        issue(3'b000, 32'd5, 32'd7, 1'b0, 32'd0, 2'b00, 2'b00, 32'd12, 32'd7);
        // immediate operand and wrap
        issue(3'b000, 32'hFFFF_FFFF, 32'h55, 1'b1, 32'd1, 2'b00, 2'b00, 32'd0, 32'h55);
        issue(3'b001, 32'd3, 32'd5, 1'b0, 32'd0, 2'b00, 2'b00, 32'hFFFF_FFFE, 32'd5);
        issue(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 2'b00, 2'b00, 32'd1, 32'd1);
        issue(3'b101, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0, 32'hFFFF_FFFF);
        issue(3'b010, 32'hF0F0, 32'h0FF0, 1'b0, 32'd0, 2'b00, 2'b00, 32'h00F0, 32'h0FF0);
        issue(3'b011, 32'hF0F0, 32'h0FF0, 1'b0, 32'd0, 2'b00, 2'b00, 32'hFFF0, 32'h0FF0);
        issue(3'b100, 32'd3, 32'd5, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd5);
        issue(3'b110, 32'd3, 32'd5, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd5);
        issue(3'b111, 32'd3, 32'd5, 1'b0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd5);

        // forwarding chain without bubbles
        issue(3'b000, 32'd10, 32'd20, 1'b0, 32'd0, 2'b00, 2'b00, 32'd30, 32'd20);
        issue(3'b000, 32'd0, 32'd1, 1'b0, 32'd0, 2'b10, 2'b00, 32'd31, 32'd1);
        issue(3'b000, 32'd0, 32'd1, 1'b0, 32'd0, 2'b10, 2'b00, 32'd32, 32'd1);
        mw_e = 1'b1;
        resw = 32'd99;
        issue(3'b000, 32'd1, 32'hBAD, 1'b0, 32'd0, 2'b00, 2'b01, 32'd100, 32'd99);
        mw_e = 1'b0;
        rs_e = 1'b1;
        issue(3'b001, 32'd7, 32'd9, 1'b0, 32'd0, 2'b01, 2'b00, 32'd90, 32'd9);
        rs_e = 1'b0;
        rw_e = 1'b0;
        issue(3'b000, 32'd4, 32'd6, 1'b0, 32'd0, 2'b11, 2'b11, 32'd10, 32'd6);
        rw_e = 1'b1;
        issue(3'b000, 32'd1, 32'd0, 1'b0, 32'd0, 2'b00, 2'b10, 32'd11, 32'd10);
        issue(3'b000, 32'd0, 32'd0, 1'b1, 32'd2, 2'b00, 2'b10, 32'd2, 32'd11);

        // branch resolution, checked combinationally within the cycle
        br_e = 1'b1;
        pc_e = 32'h100;
        issue(3'b001, 32'd8, 32'd8, 1'b0, 32'h20, 2'b00, 2'b00, 32'd0, 32'd8);
        #1 chk("PCSrcE.taken", 32'(bus.PCSrcE), 32'd1);
        chk("PCTargetE.taken", bus.PCTargetE, 32'h120);
        issue(3'b001, 32'd8, 32'd9, 1'b0, 32'h20, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd9);
        #1 chk("PCSrcE.not_taken", 32'(bus.PCSrcE), 32'd0);
        chk("PCTargetE.not_taken", bus.PCTargetE, 32'h124);
        issue(3'b010, 32'hF0, 32'h0F, 1'b0, 32'h20, 2'b00, 2'b00, 32'd0, 32'h0F);
        #1 chk("PCSrcE.and_zero", 32'(bus.PCSrcE), 32'd1);
        issue(3'b001, 32'd5, 32'd5, 1'b0, 32'h20, 2'b00, 2'b00, 32'd0, 32'd5);
        #1 chk("PCSrcE.taken2", 32'(bus.PCSrcE), 32'd1);
        chk("PCTargetE.taken2", bus.PCTargetE, 32'h12C);
        issue(3'b001, 32'd2, 32'd1, 1'b0, 32'h20, 2'b00, 2'b00, 32'd1, 32'd1);
        #1 chk("PCSrcE.not_taken2", 32'(bus.PCSrcE), 32'd0);
        br_e = 1'b0;
        issue(3'b001, 32'd4, 32'd4, 1'b0, 32'h20, 2'b00, 2'b00, 32'd0, 32'd4);
        #1 chk("PCSrcE.no_branch", 32'(bus.PCSrcE), 32'd0);
        chk("PCTargetE.no_branch", bus.PCTargetE, 32'h134);

        // asynchronous reset between edges while ALU_ResultM holds 12
        issue(3'b000, 32'd5, 32'd7, 1'b0, 32'd0, 2'b00, 2'b00, 32'd12, 32'd7);
        @(posedge clk);
        #2;
`ifdef EXECUTE_BRANCH_COUNT_EN
        chk("BranchTakenCnt", taken_cnt, 32'd3);
`endif
        #1 rst = 1'b0;
        #1;
        chk("async_rst.ALU_ResultM", bus.ALU_ResultM, 32'd0);
        chk("async_rst.RD_M", 32'(bus.RD_M), 32'd0);
        chk("async_rst.RegWriteM", 32'(bus.RegWriteM), 32'd0);
`ifdef EXECUTE_BRANCH_COUNT_EN
        chk("BranchTakenCnt.reset", taken_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        chk_zero("async_rst_edge");
        rst = 1'b1;
        issue(3'b000, 32'd0, 32'd3, 1'b0, 32'd0, 2'b10, 2'b00, 32'd3, 32'd3);

        // drain the scoreboard with a bounded wait
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
